// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: mixes COLS_PER_CYCLE columns per clock in place.
// Bypass walks the same schedule so final-round timing matches mixing rounds.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  logic [1:0]     col;
  logic [127:0]   work;
  logic           bypass;
  logic [127:0]   mixed;
  logic [1:0]     idx;
  logic [31:0]    column;
  int             base;
  logic           last;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Next working value: only the current column group is rewritten.
  always_comb begin
    mixed  = work;
    idx    = '0;
    column = '0;
    base   = 0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx    = col + 2'(k);
      base   = 127 - 32 * int'(idx);
      column = work[base -: 32];
      mixed[base -: 32] = bypass ? column : mix_col(column);
    end
  end

  assign last = ({1'b0, col} + 3'(COLS_PER_CYCLE)) == 3'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      work   <= '0;
      bypass <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= in_state;
            bypass <= in_bypass;
            col    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          work <= mixed;
          col  <= col + 2'(COLS_PER_CYCLE);
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              work   <= in_state;
              bypass <= in_bypass;
              col    <= '0;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) ||
                     ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign out_state = work;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three widths (1,2,4 columns/cycle)
// checked against a matrix-form GF(2^8) reference.
module tb_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [127:0] ist;
  logic         ib;
  wire  [2:0]   ir;
  wire  [2:0]   ov;
  wire  [127:0] os1, os2, os4;

  int errors;
  int checks;

  localparam logic [127:0] V1 =
    {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] E1 =
    {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_state(ist), .in_bypass(ib),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_state(os1)
  );

  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_state(ist), .in_bypass(ib),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_state(os2)
  );

  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_state(ist), .in_bypass(ib),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_state(os4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // General GF(2^8) product, shift-and-add with 0x11B reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] t;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11B;
      a = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mc(input logic [127:0] s,
                                          input logic byp);
    int coef [4];
    logic [127:0] r;
    logic [7:0] acc;
    coef = '{2, 3, 1, 1};
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(8'(coef[(j - row + 4) % 4]),
                           s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] os_of(input int n);
    case (n)
      0: return os1;
      1: return os2;
      default: return os4;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int n, input logic [127:0] s,
                         input logic byp,
                         output logic [127:0] res, output int lat);
    ist = s;
    ib = byp;
    iv[n] = 1'b1;
    ordy[n] = 1'b0;
    tick();
    iv[n] = 1'b0;
    ist = rnd128();
    ib = ~byp;
    lat = 0;
    while (!ov[n] && lat < 20) begin
      tick();
      lat++;
    end
    res = os_of(n);
    ordy[n] = 1'b1;
    tick();
    ordy[n] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (ir !== 3'b111 || ov !== 3'b000) begin
      errors++;
      $display("FAIL reset_hs: ir=%b ov=%b want ir=111 ov=000", ir, ov);
    end
    checks++;
    if (os1 !== '0 || os2 !== '0 || os4 !== '0) begin
      errors++;
      $display("FAIL reset_out: got %h %h %h want 0", os1, os2, os4);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vector1();
    logic [127:0] res;
    int lat;
    run_one(0, V1, 1'b0, res, lat);
    checks++;
    if (res !== E1) begin
      errors++;
      $display("FAIL vec1_data: got %h want %h", res, E1);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL vec1_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_latency();
    logic [127:0] s, res;
    int lat;
    for (int n = 0; n < 3; n++) begin
      s = {32'hd4d4d4d5, 32'h2d26314c, $urandom, $urandom};
      run_one(n, s, 1'b0, res, lat);
      checks++;
      if (res[127:64] !== {32'hd5d5d7d6, 32'h4d7ebdf8}) begin
        errors++;
        $display("FAIL cols01_dut%0d: got %h want d5d5d7d64d7ebdf8",
                 n, res[127:64]);
      end
      checks++;
      if (res !== ref_mc(s, 1'b0)) begin
        errors++;
        $display("FAIL full_dut%0d: got %h want %h",
                 n, res, ref_mc(s, 1'b0));
      end
      checks++;
      if (lat !== (4 >> n)) begin
        errors++;
        $display("FAIL latency_dut%0d: got %0d want %0d",
                 n, lat, 4 >> n);
      end
    end
  endtask

  task automatic test_bypass();
    logic [127:0] res;
    int lat;
    for (int n = 0; n < 3; n += 2) begin
      run_one(n, V1, 1'b1, res, lat);
      checks++;
      if (res !== V1) begin
        errors++;
        $display("FAIL bypass_dut%0d: got %h want %h", n, res, V1);
      end
      checks++;
      if (lat !== (4 >> n)) begin
        errors++;
        $display("FAIL bypass_lat_dut%0d: got %0d want %0d",
                 n, lat, 4 >> n);
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] hold, s2;
    int lat;
    ist = V1;
    ib = 1'b0;
    iv[0] = 1'b1;
    ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    ist = rnd128();
    lat = 0;
    while (!ov[0] && lat < 20) begin
      tick();
      lat++;
    end
    hold = os1;
    checks++;
    if (hold !== E1) begin
      errors++;
      $display("FAIL stall_data: got %h want %h", hold, E1);
    end
    for (int i = 0; i < 10; i++) begin
      ist = rnd128();
      iv[0] = 1'b1;
      tick();
      checks++;
      if (os1 !== hold || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cyc %0d got %h ir=%b ov=%b want %h ir=0 ov=1",
                 i, os1, ir[0], ov[0], hold);
      end
    end
    s2 = rnd128();
    ist = s2;
    ib = 1'b0;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", ir[0]);
    end
    tick();
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ov=%b ir=%b want ov=0 ir=0",
               ov[0], ir[0]);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    ist = rnd128();
    lat = 0;
    while (!ov[0] && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (os1 !== ref_mc(s2, 1'b0) || lat !== 4) begin
      errors++;
      $display("FAIL b2b_result: got %h lat %0d want %h lat 4",
               os1, lat, ref_mc(s2, 1'b0));
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    ist = V1;
    ib = 1'b0;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || os1 !== '0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: ov=%b ir=%b out=%h want ov=0 ir=1 out=0",
               ov[0], ir[0], os1);
    end
    ordy[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0]) seen = 1'b1;
    end
    ordy[0] = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: got out_valid=1 want none");
    end
  endtask

  task automatic test_random(input int n, input int num);
    logic [127:0] exp_q [$];
    logic [127:0] want;
    int sent, got, cyc, budget;
    logic fin, fout;
    sent = 0;
    got = 0;
    cyc = 0;
    budget = num * 30;
    iv[n] = 1'b0;
    while (got < num && cyc < budget) begin
      if (!iv[n] && sent < num && $urandom_range(3) != 0) begin
        ist = rnd128();
        ib = ($urandom_range(3) == 0);
        iv[n] = 1'b1;
      end
      ordy[n] = ($urandom_range(2) != 0);
      #1;
      fin = iv[n] & ir[n];
      fout = ov[n] & ordy[n];
      if (fout) begin
        checks++;
        want = (exp_q.size() > 0) ? exp_q[0] : '0;
        if (exp_q.size() == 0 || os_of(n) !== want) begin
          errors++;
          $display("FAIL random_dut%0d #%0d: got %h want %h",
                   n, got, os_of(n), want);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (fin) begin
        exp_q.push_back(ref_mc(ist, ib));
        sent++;
      end
      tick();
      cyc++;
      if (fin) begin
        iv[n] = 1'b0;
        ist = rnd128();
        ib = $urandom_range(1) != 0;
      end
    end
    iv[n] = 1'b0;
    ordy[n] = 1'b0;
    checks++;
    if (got !== num || exp_q.size() !== 0 || sent !== num) begin
      errors++;
      $display("FAIL random_count_dut%0d: got %0d sent %0d left %0d want %0d",
               n, got, sent, exp_q.size(), num);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    iv = '0;
    ordy = '0;
    ist = '0;
    ib = 1'b0;
    test_reset();
    test_vector1();
    test_latency();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 200);
    test_random(2, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
